// File: rtl/complement_pkg.sv
// Shared types and constants for the serial two's-complement negation unit.
// The optional NEG_SATURATE_EN build uses most_pos_f to clamp the result
// when the operand is the most-negative value.
package complement_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Returns 1 followed by (w-1) zeros in the low w bits.
  function automatic logic [63:0] most_neg_f(input int unsigned w);
    most_neg_f = 64'd1 << (w - 32'd1);
  endfunction

  // Returns 0 followed by (w-1) ones in the low w bits.
  function automatic logic [63:0] most_pos_f(input int unsigned w);
    most_pos_f = (64'd1 << (w - 32'd1)) - 64'd1;
  endfunction

endpackage

// File: rtl/complement_bit_cell.sv
// One-bit serial negation cell.
// It tracks whether a 1 has already been seen in lower bit positions.
// Until the first 1 has been seen, each bit is copied through; after that,
// each bit is inverted.
module complement_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic bit_out,
  output logic seen_one
);

  logic seen_one_r;

  // Remember whether any 1 has already passed through in this operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_one_r <= 1'b0;
    end else if (clear) begin
      seen_one_r <= 1'b0;
    end else if (enable) begin
      seen_one_r <= seen_one_r | bit_in;
    end else begin
      seen_one_r <= seen_one_r;
    end
  end

  assign bit_out  = seen_one_r ? ~bit_in : bit_in;
  assign seen_one = seen_one_r;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Bit-serial two's-complement negation controller.
// It accepts one operand through a valid/ready handshake.
// It then processes one bit per clock, LSB first, for WIDTH clocks.
// It holds the result and the overflow flag until the consumer accepts them.
// Optional build macro: NEG_SATURATE_EN.
// When NEG_SATURATE_EN is defined, negating the most-negative operand
// returns the most-positive value instead of the wrapped result.
module serial_negate_ctrl
  import complement_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
`ifdef NEG_SATURATE_EN
  localparam logic [WIDTH-1:0] MOST_POS = WIDTH'(most_pos_f(WIDTH));
`endif

  state_e             state_r;
  state_e             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sreg_r;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               accept_s;
  logic               last_s;
  logic               shift_en_s;
  logic               bit_out_s;
  logic               seen_one_s;
  logic [WIDTH-1:0]   res_next_s;
  logic               ovf_s;

  complement_bit_cell u_cell (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept_s),
    .enable   (shift_en_s),
    .bit_in   (sreg_r[0]),
    .bit_out  (bit_out_s),
    .seen_one (seen_one_s)
  );

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    shift_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // The result bit enters from the MSB side.
  // Overflow means the first 1 appears on the MSB cycle.
  always_comb begin
    res_next_s = {bit_out_s, out_data_r[WIDTH-1:1]};
    ovf_s      = last_s & ~seen_one_s & sreg_r[0];
  end

  // State register and registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Datapath: load the operand, shift one bit per clock, and capture the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      sreg_r     <= {WIDTH{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
      out_ovf_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      sreg_r     <= in_data;
      out_data_r <= out_data_r;
      out_ovf_r  <= out_ovf_r;
    end else if (shift_en_s) begin
      cnt_r      <= cnt_r + CNT_W'(1);
      sreg_r     <= sreg_r >> 1;
`ifdef NEG_SATURATE_EN
      if (ovf_s) begin
        out_data_r <= MOST_POS;
      end else begin
        out_data_r <= res_next_s;
      end
`else
      out_data_r <= res_next_s;
`endif
      if (last_s) begin
        out_ovf_r <= ovf_s;
      end else begin
        out_ovf_r <= 1'b0;
      end
    end else begin
      cnt_r      <= cnt_r;
      sreg_r     <= sreg_r;
      out_data_r <= out_data_r;
      out_ovf_r  <= out_ovf_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign busy      = busy_r;

endmodule

// File: doc/serial_negate_ctrl.md
Name: serial_negate_ctrl

Overview:
Sequential controller for the two's-complement negation datapath. It runs the rule "copy bits up to and including the first 1 from the LSB, invert every bit above it" bit-serially, one bit per clock, LSB first.
- Input side: valid/ready handshake accepts one operand.
- Output side: valid/ready handshake presents the negated result and an overflow flag.
- Sits between an operand producer and an ALU result bus. Replaces the level-sensitive complementer with a clocked, deterministic-latency unit.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-index counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand present
in_ready  output  1  block can accept operand
in_data  input  WIDTH  operand, two's complement
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  negated result
out_ovf  output  1  operand was the most-negative value (1 followed by zeros)
busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0, counter=0, seen_one=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shift register with in_data, clear counter and seen_one, go to SHIFT.
  - in_data is sampled only at this edge.
- SHIFT:
  - in_ready=0. Each clock processes bit b = sreg[0].
  - Result bit = seen_one ? ~b : b. It shifts into the result register from the MSB side.
  - seen_one <= seen_one | b. Counter increments.
  - When counter==WIDTH-1, go to DONE on that edge.
- DONE:
  - out_valid=1. out_data and out_ovf hold stable until out_valid&&out_ready.
  - On handshake: go to IDLE and drop out_valid.
  - No same-cycle re-accept: in_ready rises the cycle after the handshake.
- Latency: accept edge E0; out_valid is high after edge E_WIDTH (WIDTH clocks). Minimum initiation interval is WIDTH+2 cycles.
- Overflow: out_ovf=1 iff the operand is 1 followed by WIDTH-1 zeros. Detected serially: seen_one is first set on the MSB cycle. Without the optional feature, out_data equals the operand.
- Zero operand: out_data=0, out_ovf=0.
- in_valid while busy is ignored; the producer must hold it. A pending operand is accepted on the first IDLE cycle.
- out_ready asserted without out_valid has no effect.
- rst mid-SHIFT or mid-DONE: the operation is aborted and nothing is emitted. All outputs take reset values on the next edge.

Optional Feature:
Macro NEG_SATURATE_EN.
- Defined: when an overflow is detected, out_data = 0 followed by WIDTH-1 ones (the most-positive value), and out_ovf=1.
- Undefined: out_data is the wrapped result (equals the operand), and out_ovf=1.
- Latency and handshakes are identical in both builds.

Decomposition:
- Package complement_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - default WIDTH constant
  - function that builds the most-negative constant
  - function that builds the most-positive constant
- Sub-module complement_bit_cell:
  - inputs: clk, rst, clear, enable, bit_in
  - outputs: bit_out, seen_one
  - holds the seen_one flop and the copy/invert mux
- Top module holds the FSM, counter, shift registers and handshakes.

Test Plan:
- WIDTH=8, in_data=0x05 -> out_data=0xFB, out_ovf=0; out_valid exactly 8 clocks after accept.
- in_data=0x00 -> 0x00, ovf=0; in_data=0xFF -> 0x01, ovf=0; in_data=0x7F -> 0x81.
- in_data=0x80 -> out_data=0x80, out_ovf=1; with NEG_SATURATE_EN defined -> 0x7F, ovf=1.
- out_ready held low 5 cycles in DONE -> out_valid, out_data and out_ovf stable; in_ready stays 0; result completes on out_ready.
- in_valid held continuously with new data each transaction -> in_ready pulses once per WIDTH+2 cycles; no operand lost or duplicated.
- rst asserted at SHIFT bit 3 -> next cycle: IDLE, in_ready=1, out_valid=0; next operand 0x02 -> 0xFE correct.
